av2_coeff_encoder: RTL



---
 rtl/av2_coeff_pkg.sv | 41 ++++
 rtl/av2_coeff_buf.sv | 26 ++
 rtl/av2_coeff_encoder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/av2_coeff_pkg.sv
// Shared coefficient-token definitions for the AV2 encoder and decoder sides.
// Holds the tokenizer state enum, the reserved symbol codes, the tx_size to
// coefficient-count mapping and the 15-bit saturating clip.
package av2_coeff_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_EMIT,
    S_EOB,
    S_DONE
  } state_e;

  localparam logic [15:0] EOB_SYM  = 16'h8000;
  localparam logic [15:0] SYM_ZERO = 16'h0000;
  localparam int          IDX_W    = 13;  // wide enough to hold 4096 without wrapping

  // Coefficient count for a square transform of the given width; unknown widths fall back to 16x16.
  function automatic logic [IDX_W-1:0] tx_count(input logic [5:0] tx);
    case (tx)
      6'd4:    return 13'd16;
      6'd8:    return 13'd64;
      6'd16:   return 13'd256;
      6'd32:   return 13'd1024;
      6'd64:   return 13'd4096;
      default: return 13'd256;
    endcase
  endfunction

  function automatic logic [14:0] sat15(input logic signed [15:0] c);
    if (c > 16'sd16383)       return 15'h3FFF;
    else if (c < -16'sd16384) return 15'h4000;
    else                      return c[14:0];
  endfunction

  function automatic logic clips15(input logic signed [15:0] c);
    return (c > 16'sd16383) || (c < -16'sd16384);
  endfunction

endpackage

// File: rtl/av2_coeff_buf.sv
// Coefficient buffer: single-port synchronous RAM with registered read.
// Ports: clk; we/wdata write at addr; re loads rdata from addr on the next edge.
// Contents are not reset; rdata holds its value while re is low.
module av2_coeff_buf #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/av2_coeff_encoder.sv
// AV2 coefficient tokenizer. Buffers one transform block of quantized
// coefficients (scan order), tracks the last non-zero position, then emits one
// 16-bit symbol per position up to last_nz followed by an EOB symbol.
// Ports:
//   clk, rst_n (async active-low)
//   start, tx_size           : begin a block (sampled in IDLE)
//   coeff_in/_valid/_ready   : coefficient input stream (ready only in LOAD)
//   symbol_out/_valid/_ready : token stream to the entropy coder
//   num_coeffs               : last_nz+1, or 0 for an all-zero block
//   sat_flag                 : some coefficient in this block was clipped
//   busy, done               : not idle / one-cycle completion pulse
module av2_coeff_encoder
  import av2_coeff_pkg::*;
#(
  parameter int MAX_COEFFS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  tx_size,
  input  logic [15:0] coeff_in,
  input  logic        coeff_in_valid,
  output logic        coeff_in_ready,
  output logic [15:0] symbol_out,
  output logic        symbol_valid,
  input  logic        symbol_ready,
  output logic [15:0] num_coeffs,
  output logic        sat_flag,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(MAX_COEFFS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] nblk_q, nblk_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic [IDX_W-1:0] emit_idx_q, emit_idx_d;
  logic [IDX_W-1:0] last_nz_q, last_nz_d;
  logic             any_nz_q, any_nz_d;
  logic             sat_q, sat_d;
  logic [15:0]      num_q, num_d;

  logic             buf_we, buf_re;
  logic [AW-1:0]    buf_addr;
  logic [15:0]      buf_wdata, buf_rdata;

  // Stored form is already the data symbol; zero clips to SYM_ZERO naturally.
  assign buf_wdata = {1'b0, sat15(coeff_in)};
  assign buf_addr  = (state_q == S_LOAD) ? load_idx_q[AW-1:0] : emit_idx_q[AW-1:0];

  av2_coeff_buf #(.DEPTH(MAX_COEFFS), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .re    (buf_re),
    .addr  (buf_addr),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    nblk_d     = nblk_q;
    load_idx_d = load_idx_q;
    emit_idx_d = emit_idx_q;
    last_nz_d  = last_nz_q;
    any_nz_d   = any_nz_q;
    sat_d      = sat_q;
    num_d      = num_q;
    buf_we     = 1'b0;
    buf_re     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d     = tx_count(tx_size);
          load_idx_d = '0;
          emit_idx_d = '0;
          last_nz_d  = '0;
          any_nz_d   = 1'b0;
          sat_d      = 1'b0;
          num_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (coeff_in_valid) begin
          buf_we = 1'b1;
          // Zero test on the raw value: a clipped coefficient is never zero anyway.
          if (coeff_in != 16'h0000) begin
            last_nz_d = load_idx_q;
            any_nz_d  = 1'b1;
          end
          if (clips15(coeff_in)) sat_d = 1'b1;
          load_idx_d = load_idx_q + 13'd1;
          if (load_idx_q == nblk_q - 13'd1) begin
            num_d   = any_nz_d ? ({3'b000, last_nz_d} + 16'd1) : 16'd0;
            state_d = any_nz_d ? S_FETCH : S_EOB;
          end
        end
      end
      S_FETCH: begin
        buf_re  = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (symbol_ready) begin
          if (emit_idx_q == last_nz_q) begin
            state_d = S_EOB;
          end else begin
            emit_idx_d = emit_idx_q + 13'd1;
            state_d    = S_FETCH;
          end
        end
      end
      S_EOB:   if (symbol_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      nblk_q     <= '0;
      load_idx_q <= '0;
      emit_idx_q <= '0;
      last_nz_q  <= '0;
      any_nz_q   <= 1'b0;
      sat_q      <= 1'b0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      load_idx_q <= load_idx_d;
      emit_idx_q <= emit_idx_d;
      last_nz_q  <= last_nz_d;
      any_nz_q   <= any_nz_d;
      sat_q      <= sat_d;
      num_q      <= num_d;
    end
  end

  // The RAM output register only changes on a FETCH read, so the symbol is stable through EMIT.
  assign symbol_out     = (state_q == S_EMIT) ? buf_rdata :
                          (state_q == S_EOB)  ? EOB_SYM   : SYM_ZERO;
  assign symbol_valid   = (state_q == S_EMIT) || (state_q == S_EOB);
  assign coeff_in_ready = (state_q == S_LOAD);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign num_coeffs     = num_q;
  assign sat_flag       = sat_q;

endmodule
